// File: rtl/riscv_regfile_sb_if.sv
// riscv_regfile_sb_if -- bundle of the register file's read, issue and
// writeback signals.
//   master : decoder/execute side (drives addresses, issue and writeback)
//   slave  : register file (returns read data, issue_ready, wb_ready,
//            pend_cnt, wb_err)
// Parameters: XLEN data width, AW register address width.
interface riscv_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic            issue_ready;
  logic            issue_rd_we;
  logic [AW-1:0]   issue_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [5:0]      pend_cnt;
  logic            wb_err;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_rd_we, issue_rd,
           wb_valid, wb_rd, wb_data,
    input  rs1_data, rs2_data, issue_ready, wb_ready, pend_cnt, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_rd_we, issue_rd,
           wb_valid, wb_rd, wb_data,
    output rs1_data, rs2_data, issue_ready, wb_ready, pend_cnt, wb_err
  );
endinterface

// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb -- architectural register file with a write scoreboard.
// Two combinational read ports, one writeback port, and a busy bit per
// register that stalls issue on RAW/WAW hazards.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : riscv_regfile_sb_if.slave (reads, issue handshake, writeback
//            handshake, pend_cnt, sticky wb_err)
// Optional feature: define REGFILE_BYPASS_EN to forward wb_data onto the
// read ports and let a dependent instruction issue in its producer's
// writeback cycle. Default build has no forwarding.
module riscv_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_regfile_sb_if.slave bus
);

  logic [NUM_REGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [NUM_REGS-1:0]           busy_q, busy_d, busy_eff;
  logic [5:0]                    pend_q, pend_d;
  logic                          err_q, err_d;

  logic wb_acc, wb_wr, iss_acc, set_en, clr_en, hz, inc, dec;

  // wb_ready simply follows reset so no writeback is taken while in reset.
  assign bus.wb_ready = rst_n;
  assign wb_acc       = bus.wb_valid & bus.wb_ready;
  assign wb_wr        = wb_acc & (bus.wb_rd != '0);

  always_comb begin
    busy_eff = busy_q;
`ifdef REGFILE_BYPASS_EN
    // A register being written back this cycle no longer blocks issue.
    if (wb_acc) busy_eff[bus.wb_rd] = 1'b0;
`endif
    busy_eff[0] = 1'b0;
  end

  assign hz = busy_eff[bus.rs1_addr] | busy_eff[bus.rs2_addr] |
              (bus.issue_rd_we & busy_eff[bus.issue_rd]);
  assign bus.issue_ready = ~hz;

  assign iss_acc = bus.issue_valid & bus.issue_ready;
  assign set_en  = iss_acc & bus.issue_rd_we & (bus.issue_rd != '0);
  assign clr_en  = wb_wr & busy_q[bus.wb_rd];

  // Counter delta mirrors the popcount change of busy: a set on a register
  // that is already busy can only happen when the same register is cleared
  // in this cycle, and then the two cancel.
  assign inc = set_en & ~busy_q[bus.issue_rd];
  assign dec = clr_en & ~(set_en & (bus.issue_rd == bus.wb_rd));

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    pend_d = pend_q;
    err_d  = err_q;
    if (wb_wr) begin
      mem_d[bus.wb_rd]  = bus.wb_data;
      busy_d[bus.wb_rd] = 1'b0;
      if (!busy_q[bus.wb_rd]) err_d = 1'b1;
    end
    // Set after clear so an issue and a writeback to the same register
    // leave it busy.
    if (set_en) busy_d[bus.issue_rd] = 1'b1;
    if (inc && !dec)      pend_d = pend_q + 6'd1;
    else if (dec && !inc) pend_d = pend_q - 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.rs1_data = (bus.rs1_addr == '0) ? '0 : mem_q[bus.rs1_addr];
    bus.rs2_data = (bus.rs2_addr == '0) ? '0 : mem_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_acc && bus.rs1_addr != '0 && bus.wb_rd == bus.rs1_addr)
      bus.rs1_data = bus.wb_data;
    if (wb_acc && bus.rs2_addr != '0 && bus.wb_rd == bus.rs2_addr)
      bus.rs2_data = bus.wb_data;
`endif
  end

  assign bus.pend_cnt = pend_q;
  assign bus.wb_err   = err_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: directed scenarios plus random
// traffic, compared against a register-array/busy-set reference model.
module tb_riscv_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus();
  riscv_regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // reference model
  logic [XLEN-1:0] m_mem [NR];
  bit              m_busy[NR];
  bit              m_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] obs_rs1, obs_rs2;
  logic            obs_rdy, obs_err;
  logic [5:0]      obs_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  // register blocks issue this cycle
  function automatic bit m_blk(input int r);
    if (r == 0 || !m_busy[r]) return 1'b0;
    if (BYP && bus.wb_valid && int'(bus.wb_rd) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] m_rd(input int a);
    if (a == 0) return '0;
    if (BYP && bus.wb_valid && int'(bus.wb_rd) == a) return bus.wb_data;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.issue_valid = 1'b0; bus.issue_rd_we = 1'b0; bus.issue_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model
  // at the following rising edge.
  task automatic step(input bit iv, input bit iwe, input int ird,
                      input bit wv, input int wrd, input logic [XLEN-1:0] wd,
                      input int r1, input int r2);
    bit exp_rdy;
    @(negedge clk);
    bus.issue_valid = iv; bus.issue_rd_we = iwe; bus.issue_rd = AW'(ird);
    bus.wb_valid = wv; bus.wb_rd = AW'(wrd); bus.wb_data = wd;
    bus.rs1_addr = AW'(r1); bus.rs2_addr = AW'(r2);
    #1;
    exp_rdy = !(m_blk(r1) || m_blk(r2) || (iwe && m_blk(ird)));
    chk("issue_ready", bus.issue_ready, exp_rdy);
    chk("rs1_data", bus.rs1_data, m_rd(r1));
    chk("rs2_data", bus.rs2_data, m_rd(r2));
    chk("pend_cnt", bus.pend_cnt, m_cnt());
    chk("wb_err", bus.wb_err, m_err);
    chk("wb_ready", bus.wb_ready, 1'b1);
    obs_rdy = bus.issue_ready; obs_rs1 = bus.rs1_data; obs_rs2 = bus.rs2_data;
    obs_pend = bus.pend_cnt; obs_err = bus.wb_err;
    @(posedge clk);
    if (wv && wrd != 0) begin
      if (!m_busy[wrd]) m_err = 1'b1;
      m_mem[wrd]  = wd;
      m_busy[wrd] = 1'b0;
    end
    if (iv && exp_rdy && iwe && ird != 0) m_busy[ird] = 1'b1;
  endtask

  task automatic rand_traffic(input int cycles);
    int q[$];
    int wrd;
    bit wv;
    for (int c = 0; c < cycles; c++) begin
      q.delete();
      for (int i = 1; i < NR; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(1, 0) == 1) begin
        wv = 1'b1;
        wrd = q[$urandom_range(q.size() - 1, 0)];
      end else begin
        wv = ($urandom_range(7, 0) == 0);
        wrd = $urandom_range(7, 0);
      end
      step($urandom_range(1, 0), $urandom_range(3, 0) != 0, $urandom_range(7, 0),
           wv, wrd, $urandom, $urandom_range(7, 0), $urandom_range(7, 0));
    end
  endtask

  initial begin
    idle_inputs();
    m_reset();
    // reset state
    #12;
    bus.rs1_addr = AW'(5); bus.rs2_addr = AW'(31);
    #1;
    chk("rst_rs1", bus.rs1_data, 0);
    chk("rst_rs2", bus.rs2_data, 0);
    chk("rst_pend", bus.pend_cnt, 0);
    chk("rst_err", bus.wb_err, 0);
    chk("rst_wb_ready", bus.wb_ready, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_wb_ready", bus.wb_ready, 1);
    chk("rel_issue_ready", bus.issue_ready, 1);

    // basic write/read
    step(1, 1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    chk("basic_pend1", obs_pend, 1);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    chk("basic_rd", obs_rs1, 32'hDEADBEEF);
    chk("basic_pend0", obs_pend, 0);
    chk("basic_err", obs_err, 0);

    // x0 handling
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_rd", obs_rs2, 0);
    chk("x0_pend", obs_pend, 0);
    chk("x0_err", obs_err, 0);

    // RAW stall on x7
    step(1, 1, 7, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 7, 0);
    chk("raw_stall", obs_rdy, 0);
    step(1, 0, 0, 1, 7, 32'hA5A5_5A5A, 7, 0);
    chk("raw_wb_cycle_rdy", obs_rdy, BYP);
    if (BYP) chk("raw_bypass_data", obs_rs1, 32'hA5A5_5A5A);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    chk("raw_after_rdy", obs_rdy, 1);
    chk("raw_after_data", obs_rs1, 32'hA5A5_5A5A);

    // same-cycle set/clear on x3
    step(1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 3, 32'd5, 0, 0);
    chk("sc_pend_before", obs_pend, 1);
    step(0, 1, 3, 0, 0, 0, 3, 0);
    chk("sc_mem", obs_rs1, 5);
    chk("sc_pend", obs_pend, BYP ? 1 : 0);
    chk("sc_busy", obs_rdy, !BYP);
    if (BYP) step(0, 0, 0, 1, 3, 32'd6, 0, 0);

    // spurious writeback
    step(0, 0, 0, 1, 9, 32'd1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    chk("spur_err", obs_err, 1);
    chk("spur_data", obs_rs1, 1);

    rand_traffic(300);
    chk("err_sticky", bus.wb_err, 1);

    // async reset mid-sequence, checked before any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_err", bus.wb_err, 0);
    chk("arst_pend", bus.pend_cnt, 0);
    chk("arst_wb_ready", bus.wb_ready, 0);
    m_reset();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rand_traffic(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
- Architectural register file with a scoreboard. Sits between the decoder/control stage and the execute datapath.
- Supplies rs1/rs2 operand values to execute and accepts results from execute on a writeback handshake.
- Tracks registers with an in-flight write and holds issue (back-pressure) on RAW and WAW hazards.
- Replaces per-stage register storage: all architectural state lives in this one block.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width; must satisfy 2**AW == NUM_REGS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port A address.
- rs1_data  out  XLEN  read port A data (combinational).
- rs2_addr  in  AW  read port B address.
- rs2_data  out  XLEN  read port B data (combinational).
- issue_valid  in  1  decoder presents an instruction for issue.
- issue_ready  out  1  block accepts the issue this cycle (no hazard).
- issue_rd_we  in  1  issued instruction writes rd.
- issue_rd  in  AW  destination of issued instruction.
- wb_valid  in  1  execute presents a result.
- wb_ready  out  1  always 1 out of reset; 0 while rst_n is low.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- pend_cnt  out  6  number of busy registers (0..31).
- wb_err  out  1  sticky flag: writeback targeted a register that was not busy.

Behaviour:
- Reset (async assert, sync deassert expected externally): all registers 0, busy[31:0] = 0, pend_cnt = 0, wb_err = 0, issue_ready = 1 when issue_valid is 0.
- Reads: address 0 → 0. Otherwise mem[addr]. Bypass behaviour is defined under Optional Feature.
- Write: on wb_valid && wb_ready && wb_rd != 0, mem[wb_rd] <= wb_data at the clock edge; busy[wb_rd] <= 0.
- Writes to x0 are dropped. They still complete the handshake and never raise wb_err.
- Hazard: hz = busy_eff[rs1_addr] | busy_eff[rs2_addr] | (issue_rd_we & busy_eff[issue_rd]).
  - busy_eff[0] is always 0.
  - issue_ready = ~hz. It is asserted regardless of issue_valid, with no dependence on issue_valid.
- Issue accept = issue_valid && issue_ready. On accept with issue_rd_we && issue_rd != 0, busy[issue_rd] <= 1.
- Same-register set and clear in one cycle (accepted issue and accepted writeback both target reg r): set wins, busy[r] = 1 next cycle, mem[r] is updated.
- pend_cnt tracks popcount(busy). It updates on the same edge: +1 on set only, −1 on clear only, unchanged on set+clear of the same register, ±0 net on set of r and clear of a different s.
- wb_err: set when an accepted writeback has wb_rd != 0 and busy[wb_rd] == 0. Cleared only by reset.
- Latency: a written value is visible on the combinational read ports the cycle after the write edge (0 cycles with bypass).
- Reset mid-operation: all pending state is lost and busy is cleared. No writeback is ever lost silently: a writeback arriving during reset is not accepted (wb_ready = 0).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read ports forward wb_data when wb_valid && wb_rd == addr && addr != 0.
  - busy_eff[r] = busy[r] & ~(wb_valid && wb_rd == r), so a dependent instruction issues in the same cycle its producer writes back.
- Undefined:
  - No forwarding; busy_eff = busy.
  - A dependent instruction issues the cycle after the writeback edge.

Test Plan:
- Reset check: hold rst_n = 0 → all reads return 0, pend_cnt = 0, wb_err = 0, wb_ready = 0. Release → wb_ready = 1, issue_ready = 1.
- Basic write/read: wb x5 = 32'hDEADBEEF with busy[5] pre-set via issue → next cycle rs1_addr = 5 reads 32'hDEADBEEF, pend_cnt 1 → 0, wb_err stays 0.
- x0 handling: issue rd = 0 with we, then wb x0 = 32'h1234 → rs2_addr = 0 reads 0, pend_cnt stays 0, wb_err stays 0.
- RAW stall: issue rd = 7, then present rs1_addr = 7 → issue_ready = 0 until wb x7.
  - With REGFILE_BYPASS_EN: issue_ready = 1 and rs1_data = wb_data in the wb cycle.
  - Without the macro: issue_ready = 1 one cycle after the wb cycle.
- Same-cycle set/clear: busy[3] = 1, wb x3 = 5 plus issue rd = 3 accepted in the same cycle (bypass build) → busy[3] = 1, mem[3] = 5, pend_cnt unchanged.
- Spurious wb: wb x9 = 1 with busy[9] = 0 → wb_err = 1 and stays 1 after further traffic; async reset mid-sequence clears it immediately without a clock edge.
